// File: rtl/sseg_pkg.sv
// Shared types and constants for the serial seven-segment driver.
// Segment bytes are {dp,g,f,e,d,c,b,a}, active-low.
package sseg_pkg;

    typedef enum logic [2:0] {
        ST_CLEAR = 3'd0,
        ST_IDLE  = 3'd1,
        ST_LOAD  = 3'd2,
        ST_SHIFT = 3'd3,
        ST_LATCH = 3'd4
    } sseg_state_t;

    localparam logic [7:0] SEG_BLANK = 8'hFF;

    // Index n holds the glyph for hex digit n; dp (bit 7) is off in every entry.
    localparam logic [15:0][7:0] HEX_GLYPHS = {
        8'h8E, 8'h86, 8'hA1, 8'hC6, 8'h83, 8'h88, 8'h90, 8'h80,
        8'hF8, 8'h82, 8'h92, 8'h99, 8'hB0, 8'hA4, 8'hF9, 8'hC0
    };

endpackage

// File: rtl/seg7_hex_encode.sv
// Combinational hex nibble to active-low segment byte, with decimal point.
module seg7_hex_encode
    import sseg_pkg::*;
(
    input  logic [3:0] nibble,
    input  logic       point,
    output logic [7:0] seg
);

    assign seg = {~point, HEX_GLYPHS[nibble][6:0]};

endmodule

// File: rtl/sseg_serial_driver.sv
// Serial driver for a chain of shift-register seven-segment digits: builds the
// frame, shifts it MSB-first on a divided serial clock, and latches it.
module sseg_serial_driver
    import sseg_pkg::*;
#(
    parameter int DIGITS     = 8,
    parameter int CLK_DIV    = 4,
    parameter int BLINK_BITS = 24,
    parameter bit AUTO       = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  mode,
    input  logic                  flash,
    input  logic [8*DIGITS-1:0]   data,
    input  logic [DIGITS-1:0]     point,
    input  logic [DIGITS-1:0]     les,
    output logic                  seg_clk,
    output logic                  seg_sout,
    output logic                  seg_pen,
    output logic                  seg_clrn,
    output logic                  busy,
    output logic                  done,
    output sseg_state_t           fsm_state
);

    localparam int NBITS = 8 * DIGITS;
    localparam int BW    = $clog2(NBITS);
    localparam int CW    = $clog2(2 * CLK_DIV + 1);

    localparam logic [CW-1:0] HALF     = CW'(CLK_DIV);
    localparam logic [CW-1:0] BIT_LAST = CW'(2 * CLK_DIV - 1);
    localparam logic [CW-1:0] CLR_LAST = CW'(2 * CLK_DIV);
    localparam logic [BW-1:0] BIT_MAX  = BW'(NBITS - 1);

    sseg_state_t           state, state_next;
    logic [CW-1:0]         div_cnt;
    logic [BW-1:0]         bit_cnt;
    logic [NBITS-1:0]      shreg;
    logic [NBITS-1:0]      last_sent;
    logic [NBITS-1:0]      pattern;
    logic                  pending;
    logic [BLINK_BITS-1:0] blink_cnt;
    logic                  blink_phase;

    assign blink_phase = blink_cnt[BLINK_BITS-1];

    // Per-digit pattern: hex or raw source, then blink override.
    for (genvar i = 0; i < DIGITS; i++) begin : g_digit
        logic [7:0] hex_seg;
        logic [7:0] src_seg;

        seg7_hex_encode u_enc (
            .nibble (data[4*i +: 4]),
            .point  (point[i]),
            .seg    (hex_seg)
        );

        assign src_seg = mode ? data[8*i +: 8] : hex_seg;
        assign pattern[8*i +: 8] = (flash && les[i] && blink_phase) ? SEG_BLANK : src_seg;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_CLEAR;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_CLEAR: if (div_cnt == CLR_LAST) state_next = ST_IDLE;
            ST_IDLE:  if (start || pending || (AUTO && (pattern != last_sent)))
                          state_next = ST_LOAD;
            ST_LOAD:  state_next = ST_SHIFT;
            ST_SHIFT: if ((div_cnt == BIT_LAST) && (bit_cnt == BIT_MAX))
                          state_next = ST_LATCH;
            ST_LATCH: state_next = ST_IDLE;
            default:  state_next = ST_CLEAR;
        endcase
    end

    always_comb begin
        seg_clk  = 1'b0;
        seg_sout = 1'b1;
        seg_pen  = 1'b0;
        seg_clrn = 1'b1;
        done     = 1'b0;
        busy     = (state != ST_IDLE);
        case (state)
            ST_CLEAR: seg_clrn = 1'b0;
            ST_IDLE:  seg_pen  = 1'b1;
            ST_SHIFT: begin
                seg_clk  = (div_cnt >= HALF);
                seg_sout = shreg[NBITS-1];
            end
            ST_LATCH: begin
                seg_pen = 1'b1;
                done    = 1'b1;
            end
            default: ;
        endcase
    end

    assign fsm_state = state;

    // div_cnt times the clear pulse in CLEAR and one full serial bit in SHIFT.
    always_ff @(posedge clk) begin
        if (rst) begin
            div_cnt   <= '0;
            bit_cnt   <= '0;
            shreg     <= '1;
            last_sent <= '1;
            pending   <= 1'b0;
            blink_cnt <= '0;
        end else begin
            blink_cnt <= blink_cnt + 1'b1;

            // A start arriving in LOAD wins over the clear so it is not lost.
            if ((state == ST_CLEAR) && (div_cnt == CLR_LAST)) begin
                pending <= 1'b1;
            end else if (start && (state != ST_IDLE)) begin
                pending <= 1'b1;
            end else if (state == ST_LOAD) begin
                pending <= 1'b0;
            end

            case (state)
                ST_CLEAR: begin
                    div_cnt <= (div_cnt == CLR_LAST) ? '0 : div_cnt + 1'b1;
                end
                ST_LOAD: begin
                    shreg     <= pattern;
                    last_sent <= pattern;
                    div_cnt   <= '0;
                    bit_cnt   <= '0;
                end
                ST_SHIFT: begin
                    if (div_cnt == BIT_LAST) begin
                        div_cnt <= '0;
                        bit_cnt <= bit_cnt + 1'b1;
                        shreg   <= {shreg[NBITS-2:0], 1'b1};
                    end else begin
                        div_cnt <= div_cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_sseg_serial_driver.sv
// Directed bench for sseg_serial_driver: captures shifted frames off the serial
// pins and compares them against hand-computed segment patterns.
module tb_sseg_serial_driver;
  import sseg_pkg::*;

  localparam int DIGITS     = 8;
  localparam int CLK_DIV    = 4;
  localparam int BLINK_BITS = 4;

  // Digits 7..0 shifted first to last.
  localparam logic [63:0] HEX_A  = 64'hC0F9A4B0999282F8;  // 0,1,2,3,4,5,6,7
  localparam logic [63:0] HEX_B  = 64'h80908883C6A1868E;  // 8,9,A,b,C,d,E,F
  localparam logic [63:0] HEX_DP = 64'hC0F9A4B099928278;  // HEX_A with digit0 dp lit
  localparam logic [63:0] RAW_A  = 64'h11223344556677A5;

  logic clk = 1'b0;
  logic rst, start, mode, flash;
  logic [63:0] data;
  logic [7:0] point, les;
  logic seg_clk, seg_sout, seg_pen, seg_clrn, busy, done;
  sseg_state_t fsm_state;

  int checks = 0;
  int errors = 0;
  logic [63:0] exp_q[$];
  logic [63:0] got_q[$];

  sseg_serial_driver #(
    .DIGITS(DIGITS), .CLK_DIV(CLK_DIV), .BLINK_BITS(BLINK_BITS), .AUTO(1'b1)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .mode(mode), .flash(flash),
    .data(data), .point(point), .les(les),
    .seg_clk(seg_clk), .seg_sout(seg_sout), .seg_pen(seg_pen),
    .seg_clrn(seg_clrn), .busy(busy), .done(done), .fsm_state(fsm_state)
  );

  // clock / reset block
  always #5 clk = ~clk;

  initial begin
    #900000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Frame capture off the serial pins, sampled on the falling system edge.
  initial begin
    logic prev_sclk;
    logic [63:0] cap;
    int bitc;
    prev_sclk = 1'b0;
    cap = '0;
    bitc = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        bitc = 0;
      end else begin
        if (seg_clk && !prev_sclk) begin
          cap = {cap[62:0], seg_sout};
          bitc++;
        end
        if (done) begin
          check("frame_bits", 64'(bitc), 64'd64);
          got_q.push_back(cap);
          bitc = 0;
        end
      end
      prev_sclk = seg_clk;
    end
  end

  task automatic wait_frame(input string tag, output logic [63:0] f);
    int n;
    n = 0;
    while (got_q.size() == 0 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_rx"}, 64'(got_q.size() != 0), 64'd1);
    f = '0;
    if (got_q.size() != 0) f = got_q.pop_front();
  endtask

  task automatic expect_frame(input string tag, input logic [63:0] exp);
    logic [63:0] f;
    exp_q.push_back(exp);
    wait_frame(tag, f);
    check(tag, f, exp_q.pop_front());
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  initial begin
    logic [63:0] f;
    logic [7:0] prev_d0;
    int n;

    rst = 1'b1; start = 1'b0; mode = 1'b0; flash = 1'b0;
    data = 64'h0000_0000_0123_4567; point = 8'h00; les = 8'h00;

    // Reset values and clear pulse length
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_state", 64'(fsm_state), 64'(ST_CLEAR));
    check("rst_sclk", 64'(seg_clk), 64'd0);
    check("rst_sout", 64'(seg_sout), 64'd1);
    check("rst_pen", 64'(seg_pen), 64'd0);
    check("rst_clrn", 64'(seg_clrn), 64'd0);
    check("rst_busy", 64'(busy), 64'd1);
    check("rst_done", 64'(done), 64'd0);
    rst = 1'b0;
    n = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (seg_clrn) break;
      n++;
    end
    check("clr_len", 64'(n), 64'd8);
    check("clr_exit_state", 64'(fsm_state), 64'(ST_IDLE));
    expect_frame("reset_frame", HEX_A);
    repeat (40) @(negedge clk);
    check("reset_single", 64'(got_q.size()), 64'd0);

    // Start-to-done latency with an unchanged pattern
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("load_state", 64'(fsm_state), 64'(ST_LOAD));
    n = 1;
    while (!done && n < 2000) begin
      @(negedge clk);
      n++;
      if (n == 10) begin
        check("shift_pen", 64'(seg_pen), 64'd0);
        check("shift_state", 64'(fsm_state), 64'(ST_SHIFT));
      end
    end
    check("latency", 64'(n), 64'd514);
    @(negedge clk);
    check("done_pulse", 64'(done), 64'd0);
    check("post_idle", 64'(fsm_state), 64'(ST_IDLE));
    expect_frame("hex_frame", HEX_A);

    // Starts and data change while busy
    pulse_start();
    repeat (50) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (30) @(negedge clk);
    start = 1'b1;
    data = 64'h0000_0000_89AB_CDEF;
    @(negedge clk);
    start = 1'b0;
    expect_frame("busy_old", HEX_A);
    expect_frame("busy_new", HEX_B);
    repeat (700) @(negedge clk);
    check("no_third", 64'(got_q.size()), 64'd0);

    // Raw mode: bytes pass through, point ignored
    mode = 1'b1; data = RAW_A; point = 8'hFF;
    expect_frame("raw", RAW_A);
    repeat (5) @(negedge clk);
    point = 8'h00;
    repeat (40) @(negedge clk);
    check("raw_point_ignored", 64'(got_q.size()), 64'd0);
    check("raw_idle", 64'(busy), 64'd0);

    // Hex mode decimal point on digit 0
    mode = 1'b0; data = 64'h0000_0000_0123_4567; point = 8'h01;
    expect_frame("hex_dp", HEX_DP);

    // Blink on digit 0: successive auto frames must alternate glyph / blank
    point = 8'h00; les = 8'h01; flash = 1'b1;
    prev_d0 = 8'h00;
    for (int k = 0; k < 4; k++) begin
      wait_frame("blink", f);
      check("blink_upper", 64'(f[63:8]), 64'h00C0F9A4B0999282);
      if (k == 0)
        check("blink_d0_set", 64'(f[7:0] == 8'hF8 || f[7:0] == 8'hFF), 64'd1);
      else
        check("blink_alt", 64'(f[7:0]), 64'(prev_d0 == 8'hF8 ? 8'hFF : 8'hF8));
      prev_d0 = f[7:0];
    end
    flash = 1'b0; les = 8'h00;
    repeat (1200) @(negedge clk);
    got_q.delete();

    // Reset in the middle of SHIFT
    pulse_start();
    repeat (100) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_state", 64'(fsm_state), 64'(ST_CLEAR));
    check("midrst_pen", 64'(seg_pen), 64'd0);
    check("midrst_clrn", 64'(seg_clrn), 64'd0);
    check("midrst_sclk", 64'(seg_clk), 64'd0);
    check("midrst_busy", 64'(busy), 64'd1);
    check("midrst_done", 64'(done), 64'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    repeat (30) @(negedge clk);
    check("midrst_no_frame", 64'(got_q.size()), 64'd0);
    expect_frame("post_reset", HEX_A);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/sseg_serial_driver.md
# sseg_serial_driver

Parametrised serial driver for a chain of 8-bit shift-register-driven seven-segment digits. Takes hex or raw segment data per digit, applies decimal points and per-digit blinking, and shifts the frame MSB-first over a generated serial clock. Frames are sent on request or automatically when the displayed pattern changes. Sits between the CPU/peripheral data bus and the board's serial display connector.

## Interface
- DIGITS, 8: number of digits in the chain (1..16)
- CLK_DIV, 4: clk cycles per serial-clock half period (>=1)
- BLINK_BITS, 24: width of the free-running blink counter; phase = MSB
- AUTO, 1: 1 = start a frame automatically when the pattern differs from the last one sent
---
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  frame request, sampled every cycle
- mode  in  1  0 = hex decode, 1 = raw segment bytes
- flash  in  1  global blink enable
- data  in  8*DIGITS  raw: byte i = digit i; hex: nibble i (bits 4i+3:4i) = digit i, upper half ignored
- point  in  DIGITS  1 = light decimal point of digit i (hex mode only)
- les  in  DIGITS  1 = digit i blinks when flash=1
- seg_clk  out  1  serial clock to chain
- seg_sout  out  1  serial data
- seg_pen  out  1  display enable: 0 while shifting/clearing, 1 otherwise
- seg_clrn  out  1  active-low chain clear
- busy  out  1  state != IDLE
- done  out  1  one-cycle pulse at end of frame

## Operation
- Segment byte format {dp,g,f,e,d,c,b,a}, active-low (0 = lit); blank = 8'hFF.
- Hex mode: standard 0-F glyphs; dp bit = ~point[i]. Raw mode: byte used as-is; point ignored.
- Blink: if flash & les[i] & blink_phase, digit i = 8'hFF (both modes).
- Pattern computed combinationally every cycle; last_sent register holds the pattern of the last completed frame.
- FSM: CLEAR -> IDLE -> LOAD -> SHIFT -> LATCH -> IDLE.
  - CLEAR: entered on rst; seg_clrn=0 for 2*CLK_DIV cycles after rst deasserts; then IDLE with pending set.
  - IDLE: go LOAD if start, pending, or (AUTO and pattern != last_sent).
  - LOAD: snapshot pattern into 8*DIGITS shift register and last_sent; clear pending.
  - SHIFT: 8*DIGITS bits, digit DIGITS-1 first, bit 7 first. Per bit: seg_clk=0 for CLK_DIV cycles with seg_sout valid, then seg_clk=1 for CLK_DIV cycles; seg_sout stable across rising edge.
  - LATCH: one cycle, done=1, seg_pen=1.
- start while not IDLE sets pending; multiple starts collapse into one extra frame.
- Input changes during a frame do not affect it (snapshot); caught by AUTO compare in next IDLE.
- Blink counter free-runs, cleared by rst only.

## Timing
- Reset values (cycle after rst high): state=CLEAR, seg_clk=0, seg_sout=1, seg_pen=0, seg_clrn=0, busy=1, done=0, pending=0, last_sent=all FF.
- rst mid-frame: next cycle reset values; no done pulse; frame abandoned.
- start high in IDLE at edge n: LOAD after n, SHIFT begins after n+1 (seg_pen=0), SHIFT lasts 16*DIGITS*CLK_DIV cycles, done at cycle n+2+16*DIGITS*CLK_DIV, IDLE next.
- Default params: 514 cycles start-to-done.
- seg_pen=1 in IDLE and LATCH; seg_clrn=1 everywhere except CLEAR/reset.
- seg_clk=0 whenever not in SHIFT.

## Structure
- Package sseg_pkg: state enum, 16-entry hex glyph constant table, SEG_BLANK=8'hFF.
- Sub-module seg7_hex_encode: combinational nibble+dp -> byte; instantiated per digit via generate.
- Divider counter, bit counter ($clog2(8*DIGITS)), shift register, blink counter in top.

## Test plan
- Reset: rst 3 cycles, CLK_DIV=4 -> seg_clrn=0 for 8 cycles after release, then automatic frame, done once.
- Hex frame: mode=0, data low=32'h0123_4567, point=0, les=0, start -> 64 bits on seg_clk rises, first byte 8'hC0, last byte 8'hF8, done at start+514.
- Raw + dp: mode=1, byte0=8'hA5, point=8'hFF -> byte0 shifted exactly 8'hA5, point ignored.
- Blink: BLINK_BITS=4, flash=1, les=8'h01 -> auto frames on each phase change; digit0 alternates glyph / 8'hFF, others unchanged.
- Busy handling: start twice during frame, change data mid-frame -> frame sends old snapshot, exactly one following frame with new data, no third.
- rst mid-SHIFT -> next cycle seg_pen=0, seg_clrn=0, seg_clk=0, busy=1, no done.
